clut_cache: RTL and testbench
=============================

Name: clut_cache

Overview:
- Palette (CLUT) store that sits directly downstream of the per-pixel texel-to-index stage.
- Receives the 8-bit palette indices that stage produces, two pixels per clock, and returns the 16-bit texel colours.
- Fills itself from VRAM through a block-read request/ack handshake.
- Keeps a tag of the loaded CLUT so that redundant reloads are skipped.

Parameters:
- BLOCK_WORDS, 8, 32-bit data beats per memory block request. Fixed: entry mapping depends on it.

Ports:
- clk  in  1  clock
- i_nrst  in  1  synchronous reset, active low
- i_loadReq  in  1  single-cycle request to make the CLUT at (i_clutX, i_clutY) resident
- i_clutX  in  6  CLUT X position in 16-halfword units
- i_clutY  in  9  CLUT Y line
- i_texFormat  in  2  0=4-bit, 1=8-bit, 2=16-bit, 3=reserved
- i_invalidate  in  1  VRAM was written; drop the tag
- o_busy  out  1  load in progress; lookups are not valid
- o_memReq  out  1  block read request
- o_memAddr  out  18  32-bit word address: {line[8:0], block[5:0], 3'b000}
- i_memAck  in  1  request accepted
- i_memDataValid  in  1  data beat valid
- i_memData  in  32  data beat; [15:0] is the lower entry, [31:16] the upper entry
- i_indexA  in  8  palette index, pixel A
- i_indexB  in  8  palette index, pixel B
- o_colorA  out  16  colour for i_indexA, registered
- o_colorB  out  16  colour for i_indexB, registered

Behaviour:

Reset
- o_busy=0, o_memReq=0, o_memAddr=0, o_colorA=0, o_colorB=0.
- Tag invalid; state IDLE.
- Palette RAM contents are not cleared.
- Reset asserted mid-load aborts the load immediately. The tag stays invalid.

Storage and lookup
- 256x16 RAM with two read ports and one write port.
- o_colorX <= RAM[i_indexX] every cycle: 1-cycle latency.
- Reads are performed even while busy; returned data is undefined until the load completes.

Load request, accepted only in IDLE
- i_texFormat of 2 or 3: request ignored, state unchanged.
- Hit: tag valid && tagX==i_clutX && tagY==i_clutY && (tagIs8bit || i_texFormat==0).
  - A hit starts no load; o_busy stays 0.
- Miss: latch X, Y and format; block count N = 1 for 4-bit, 16 for 8-bit.
  - Clear tag valid and the invalidate-seen flag; o_busy=1 from the next cycle.
- i_loadReq while busy is ignored. Upstream must wait for o_busy=0.

State machine
- IDLE -> REQ on a miss.
- REQ: o_memReq=1 and o_memAddr={Y, (X+blk) mod 64, 3'b000}.
  - The X field wraps within the line; Y never increments.
  - Hold the request until i_memAck, then drop o_memReq the next cycle and go to RECV.
  - i_memDataValid before ack is ignored.
- RECV: each i_memDataValid beat k (0..7) of block blk writes:
  - RAM[16*blk+2k] = data[15:0]
  - RAM[16*blk+2k+1] = data[31:16]
  - After beat 7: if blk==N-1 go to DONE, else blk+1 and back to REQ.
- DONE, one cycle:
  - Tag <= {X, Y, fmt8}.
  - Tag valid <= !invalidate-seen && !i_invalidate.
  - o_busy=0 next cycle; go to IDLE.

Invalidate
- In IDLE: clears tag valid.
- During a load: sets invalidate-seen, so the current load completes but the tag is not validated.
- i_invalidate and a hitting i_loadReq in the same IDLE cycle: invalidate wins, and the request is treated as a miss.

Write/read collision
- A lookup of an entry written in the same cycle returns the old value.

Test Plan:
- 4-bit load at X=2, Y=480 -> exactly one request with addr={480,2,0}. Beats 0x00010000+k*0x00020002 fill entries 0..15 with 0..15. o_busy high for the load then low. i_indexA=5, i_indexB=14 -> next cycle o_colorA=5, o_colorB=14.
- Repeat the same 4-bit request, then a 4-bit request after an 8-bit load at the same X/Y -> no o_memReq, o_busy stays 0. A 4-bit load followed by an 8-bit request at the same X/Y -> full 16-block reload.
- 8-bit load at X=60 -> 16 requests with block fields 60,61,62,63,0,1,...,11, all on line Y. Entry 255 comes from beat 7 [31:16] of the last block.
- Hold i_memAck low for 10 cycles -> o_memReq and o_memAddr remain stable. Insert gaps between beats -> no write or count advance without i_memDataValid.
- Pulse i_invalidate mid-load -> load completes and o_busy falls. The identical request then reloads; an invalidate-with-hit in the same cycle also reloads.
- Drop i_nrst during block 3 of an 8-bit load -> all outputs 0 next cycle. A following identical request performs a full reload. i_texFormat=2 request -> no activity.

Source files
------------

// File: rtl/clut_cache.sv
// CLUT palette cache: fills 256 16-bit entries from VRAM in 8-beat blocks and
// serves two registered colour lookups per clock; a tag skips redundant reloads.
module clut_cache #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        i_nrst,
    input  logic        i_loadReq,
    input  logic [5:0]  i_clutX,
    input  logic [8:0]  i_clutY,
    input  logic [1:0]  i_texFormat,
    input  logic        i_invalidate,
    output logic        o_busy,
    output logic        o_memReq,
    output logic [17:0] o_memAddr,
    input  logic        i_memAck,
    input  logic        i_memDataValid,
    input  logic [31:0] i_memData,
    input  logic [7:0]  i_indexA,
    input  logic [7:0]  i_indexB,
    output logic [15:0] o_colorA,
    output logic [15:0] o_colorB
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_tagValid;
    logic [5:0]        r_tagX;
    logic [8:0]        r_tagY;
    logic              r_tag8;
    logic [5:0]        r_ldX;
    logic [8:0]        r_ldY;
    logic              r_ld8;
    logic              r_invSeen;
    logic [3:0]        r_blk;
    logic [BEAT_W-1:0] r_beat;

    // Each 32-bit word holds an even/odd entry pair, so one beat is one write.
    logic [31:0]       r_ram [0:127];

    logic              w_hit;
    logic              w_start;
    logic              w_beatLast;
    logic              w_blkLast;
    logic [5:0]        w_blkX;
    logic [31:0]       w_wordA;
    logic [31:0]       w_wordB;

    assign w_hit = r_tagValid && !i_invalidate &&
                   (r_tagX == i_clutX) && (r_tagY == i_clutY) &&
                   (r_tag8 || (i_texFormat == 2'd0));
    assign w_start    = (r_state == S_IDLE) && i_loadReq && !i_texFormat[1] && !w_hit;
    assign w_beatLast = i_memDataValid && (r_beat == BEAT_W'(BLOCK_WORDS - 1));
    assign w_blkLast  = (r_blk == (r_ld8 ? 4'd15 : 4'd0));
    assign w_blkX     = r_ldX + {2'b00, r_blk};

    always_comb begin
        w_next    = r_state;
        o_busy    = (r_state != S_IDLE);
        o_memReq  = 1'b0;
        o_memAddr = '0;
        case (r_state)
            S_IDLE: if (w_start) w_next = S_REQ;
            S_REQ: begin
                o_memReq  = 1'b1;
                o_memAddr = {r_ldY, w_blkX, 3'b000};
                if (i_memAck) w_next = S_RECV;
            end
            S_RECV: if (w_beatLast) w_next = w_blkLast ? S_DONE : S_REQ;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            r_state    <= S_IDLE;
            r_tagValid <= 1'b0;
            r_tagX     <= '0;
            r_tagY     <= '0;
            r_tag8     <= 1'b0;
            r_ldX      <= '0;
            r_ldY      <= '0;
            r_ld8      <= 1'b0;
            r_invSeen  <= 1'b0;
            r_blk      <= '0;
            r_beat     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_invalidate) r_tagValid <= 1'b0;
                    if (w_start) begin
                        r_ldX      <= i_clutX;
                        r_ldY      <= i_clutY;
                        r_ld8      <= i_texFormat[0];
                        r_tagValid <= 1'b0;
                        r_invSeen  <= 1'b0;
                        r_blk      <= '0;
                        r_beat     <= '0;
                    end
                end
                S_REQ: if (i_invalidate) r_invSeen <= 1'b1;
                S_RECV: begin
                    if (i_invalidate) r_invSeen <= 1'b1;
                    if (i_memDataValid) r_beat <= r_beat + 1'b1;
                    if (w_beatLast && !w_blkLast) r_blk <= r_blk + 1'b1;
                end
                S_DONE: begin
                    r_tagX     <= r_ldX;
                    r_tagY     <= r_ldY;
                    r_tag8     <= r_ld8;
                    r_tagValid <= !r_invSeen && !i_invalidate;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_nrst && (r_state == S_RECV) && i_memDataValid)
            r_ram[{r_blk, r_beat}] <= i_memData;
    end

    // Reads sample the array before this cycle's write lands: collisions see old data.
    assign w_wordA = r_ram[i_indexA[7:1]];
    assign w_wordB = r_ram[i_indexB[7:1]];

    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            o_colorA <= '0;
            o_colorB <= '0;
        end else begin
            o_colorA <= i_indexA[0] ? w_wordA[31:16] : w_wordA[15:0];
            o_colorB <= i_indexB[0] ? w_wordB[31:16] : w_wordB[15:0];
        end
    end

endmodule

// File: tb/tb_clut_cache.sv
// Bench for clut_cache: a task-driven VRAM responder with an address queue and a
// colour scoreboard backed by a shadow copy of the palette.
module tb_clut_cache;

    logic        clk;
    logic        i_nrst;
    logic        i_loadReq;
    logic [5:0]  i_clutX;
    logic [8:0]  i_clutY;
    logic [1:0]  i_texFormat;
    logic        i_invalidate;
    logic        o_busy;
    logic        o_memReq;
    logic [17:0] o_memAddr;
    logic        i_memAck;
    logic        i_memDataValid;
    logic [31:0] i_memData;
    logic [7:0]  i_indexA;
    logic [7:0]  i_indexB;
    logic [15:0] o_colorA;
    logic [15:0] o_colorB;

    clut_cache #(.BLOCK_WORDS(8)) dut (
        .clk(clk), .i_nrst(i_nrst), .i_loadReq(i_loadReq),
        .i_clutX(i_clutX), .i_clutY(i_clutY), .i_texFormat(i_texFormat),
        .i_invalidate(i_invalidate), .o_busy(o_busy), .o_memReq(o_memReq),
        .o_memAddr(o_memAddr), .i_memAck(i_memAck),
        .i_memDataValid(i_memDataValid), .i_memData(i_memData),
        .i_indexA(i_indexA), .i_indexB(i_indexB),
        .o_colorA(o_colorA), .o_colorB(o_colorB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_ram [256];
    logic [31:0] col_q [$];
    logic [17:0] addr_q [$];
    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [7:0] a, input logic [7:0] b);
        logic [31:0] e;
        i_indexA = a;
        i_indexB = b;
        col_q.push_back({exp_ram[a], exp_ram[b]});
        tick();
        e = col_q.pop_front();
        total++;
        if ({o_colorA, o_colorB} !== e) begin
            bad++;
            $display("FAIL lookup idx=%0d/%0d got=%h/%h exp=%h/%h",
                     a, b, o_colorA, o_colorB, e[31:16], e[15:0]);
        end
    endtask

    task automatic do_load(input string name, input logic [5:0] x, input logic [8:0] y,
                           input logic [1:0] fmt, input int nblk, input logic [15:0] seed,
                           input int ackdly, input bit gaps, input bit inv_mid,
                           input bit inv_req, input bit coll, input int abort_blk);
        logic [17:0] ea;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [31:0] ce;
        int w;
        bit stable;
        for (int b = 0; b < nblk; b++) addr_q.push_back({y, 6'(x + b), 3'b000});
        i_clutX = x;
        i_clutY = y;
        i_texFormat = fmt;
        i_loadReq = 1'b1;
        i_invalidate = inv_req;
        tick();
        i_loadReq = 1'b0;
        i_invalidate = 1'b0;
        if (nblk == 0) begin
            repeat (4) begin
                total++;
                if (o_busy !== 1'b0 || o_memReq !== 1'b0) begin
                    bad++;
                    $display("FAIL %s no_activity busy=%b req=%b exp=0/0", name, o_busy, o_memReq);
                end
                tick();
            end
            return;
        end
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_rise got=%b exp=1", name, o_busy);
        end
        for (int b = 0; b < nblk; b++) begin
            w = 0;
            while (o_memReq !== 1'b1 && w < 20) begin tick(); w++; end
            total++;
            if (o_memReq !== 1'b1) begin
                bad++;
                $display("FAIL %s req_timeout blk=%0d got=%b exp=1", name, b, o_memReq);
                addr_q.delete();
                return;
            end
            ea = addr_q.pop_front();
            total++;
            if (o_memAddr !== ea) begin
                bad++;
                $display("FAIL %s addr blk=%0d got=%h exp=%h", name, b, o_memAddr, ea);
            end
            if (ackdly > 0) begin
                stable = 1'b1;
                i_memDataValid = 1'b1;
                i_memData = 32'hDEAD_BEEF;
                repeat (ackdly) begin
                    tick();
                    if (o_memReq !== 1'b1 || o_memAddr !== ea) stable = 1'b0;
                end
                total++;
                if (!stable) begin
                    bad++;
                    $display("FAIL %s req_hold req=%b addr=%h exp=1/%h", name, o_memReq, o_memAddr, ea);
                end
            end
            i_memDataValid = 1'b0;
            i_memAck = 1'b1;
            tick();
            i_memAck = 1'b0;
            total++;
            if (o_memReq !== 1'b0) begin
                bad++;
                $display("FAIL %s req_drop got=%b exp=0", name, o_memReq);
            end
            for (int k = 0; k < 8; k++) begin
                if (gaps && (k % 2 == 1)) tick();
                if (abort_blk == b && k == 3) begin
                    i_nrst = 1'b0;
                    tick();
                    total++;
                    if (o_busy !== 1'b0 || o_memReq !== 1'b0 || o_memAddr !== 18'd0 ||
                        o_colorA !== 16'd0 || o_colorB !== 16'd0) begin
                        bad++;
                        $display("FAIL %s abort busy=%b req=%b addr=%h col=%h/%h exp=all 0",
                                 name, o_busy, o_memReq, o_memAddr, o_colorA, o_colorB);
                    end
                    i_nrst = 1'b1;
                    addr_q.delete();
                    return;
                end
                lo = 16'(seed + 16 * b + 2 * k);
                hi = lo + 16'd1;
                e0 = 8'(16 * b + 2 * k);
                e1 = e0 + 8'd1;
                if (coll) begin
                    i_indexA = e0;
                    i_indexB = e1;
                    col_q.push_back({exp_ram[e0], exp_ram[e1]});
                end
                i_memDataValid = 1'b1;
                i_memData = {hi, lo};
                if (inv_mid && b == nblk - 1 && k == 3) i_invalidate = 1'b1;
                tick();
                i_memDataValid = 1'b0;
                i_invalidate = 1'b0;
                i_memData = 32'hFFFF_FFFF;
                exp_ram[e0] = lo;
                exp_ram[e1] = hi;
                if (coll) begin
                    ce = col_q.pop_front();
                    total++;
                    if ({o_colorA, o_colorB} !== ce) begin
                        bad++;
                        $display("FAIL %s collision idx=%0d got=%h/%h exp=%h/%h",
                                 name, e0, o_colorA, o_colorB, ce[31:16], ce[15:0]);
                    end
                end
            end
        end
        w = 0;
        while (o_busy !== 1'b0 && w < 10) begin tick(); w++; end
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_fall got=%b exp=0", name, o_busy);
        end
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        repeat (3) tick();
        total++;
        if (o_busy !== 1'b0 || o_memReq !== 1'b0 || o_memAddr !== 18'd0 ||
            o_colorA !== 16'd0 || o_colorB !== 16'd0) begin
            bad++;
            $display("FAIL reset busy=%b req=%b addr=%h col=%h/%h exp=all 0",
                     o_busy, o_memReq, o_memAddr, o_colorA, o_colorB);
        end
        i_nrst = 1'b1;
        tick();
    endtask

    task automatic test_load4();
        do_load("load4", 6'd2, 9'd480, 2'd0, 1, 16'h0000, 0, 0, 0, 0, 0, -1);
        lookup(8'd5, 8'd14);
        lookup(8'd0, 8'd15);
    endtask

    task automatic test_hit();
        do_load("hit4", 6'd2, 9'd480, 2'd0, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        do_load("upgrade8", 6'd2, 9'd480, 2'd1, 16, 16'h1000, 0, 0, 0, 0, 1, -1);
        lookup(8'd0, 8'd255);
        do_load("hit4_after8", 6'd2, 9'd480, 2'd0, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        do_load("hit8", 6'd2, 9'd480, 2'd1, 0, 16'h0, 0, 0, 0, 0, 0, -1);
    endtask

    task automatic test_wrap();
        do_load("wrap8", 6'd60, 9'd100, 2'd1, 16, 16'h2000, 0, 0, 0, 0, 0, -1);
        lookup(8'd255, 8'd0);
        lookup(8'd128, 8'd17);
    endtask

    task automatic test_backpressure();
        do_load("stall", 6'd10, 9'd5, 2'd0, 1, 16'h3000, 10, 1, 0, 0, 0, -1);
        lookup(8'd1, 8'd14);
        lookup(8'd15, 8'd0);
    endtask

    task automatic test_invalidate();
        do_load("inv_mid", 6'd20, 9'd7, 2'd0, 1, 16'h4000, 0, 0, 1, 0, 0, -1);
        do_load("reload_after_inv", 6'd20, 9'd7, 2'd0, 1, 16'h5000, 0, 0, 0, 0, 0, -1);
        do_load("hit_after_reload", 6'd20, 9'd7, 2'd0, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        do_load("inv_with_hit", 6'd20, 9'd7, 2'd0, 1, 16'h6000, 0, 0, 0, 1, 0, -1);
        i_invalidate = 1'b1;
        tick();
        i_invalidate = 1'b0;
        do_load("reload_after_idle_inv", 6'd20, 9'd7, 2'd0, 1, 16'h7000, 0, 0, 0, 0, 0, -1);
        lookup(8'd3, 8'd12);
    endtask

    task automatic test_reset_midload();
        do_load("abort8", 6'd30, 9'd200, 2'd1, 16, 16'h8000, 0, 0, 0, 0, 0, 3);
        do_load("reload8", 6'd30, 9'd200, 2'd1, 16, 16'h9000, 0, 0, 0, 0, 0, -1);
        lookup(8'd200, 8'd63);
    endtask

    task automatic test_format();
        do_load("fmt16", 6'd30, 9'd200, 2'd2, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        do_load("fmt_rsv", 6'd1, 9'd1, 2'd3, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        do_load("fmt16_new", 6'd5, 9'd9, 2'd2, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        do_load("hit_kept", 6'd30, 9'd200, 2'd1, 0, 16'h0, 0, 0, 0, 0, 0, -1);
        lookup(8'd99, 8'd254);
    endtask

    initial begin
        i_nrst = 1'b0;
        i_loadReq = 1'b0;
        i_clutX = '0;
        i_clutY = '0;
        i_texFormat = '0;
        i_invalidate = 1'b0;
        i_memAck = 1'b0;
        i_memDataValid = 1'b0;
        i_memData = '0;
        i_indexA = '0;
        i_indexB = '0;
        test_reset();
        test_load4();
        test_hit();
        test_wrap();
        test_backpressure();
        test_invalidate();
        test_reset_midload();
        test_format();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
